// File: rtl/sram_pkg.sv
// Shared types and helpers for the dual-port byte-enabled SRAM.
//   rw_mode_e     : read-during-write behaviour (new or old data returned)
//   sweep_state_e : post-reset zero-fill sequencer states
//   lane_addr()   : byte address of lane i, before wrap (caller truncates)
package sram_pkg;

    typedef enum logic [0:0] {
        WRITE_FIRST = 1'b0,
        READ_FIRST  = 1'b1
    } rw_mode_e;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } sweep_state_e;

    // Truncating the result to ADDR_WIDTH bits gives the wrap past the top byte.
    function automatic logic [31:0] lane_addr(input logic [31:0] addr, input logic [31:0] lane);
        return addr + lane;
    endfunction

endpackage

// File: rtl/sram_dp_be_if.sv
// Two-port request/response bundle between the memory controller and the SRAM.
//   ready               : SRAM accepting requests (init sweep finished)
//   req/we/be/addr/data : per-port request, byte address of lane 0
//   q/valid             : per-port response, valid pulses for one cycle
interface sram_dp_be_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 12
);
    localparam int unsigned BYTES = DATA_WIDTH / 8;

    logic                  ready;

    logic                  req_a;
    logic                  we_a;
    logic [BYTES-1:0]      be_a;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [DATA_WIDTH-1:0] data_a;
    logic [DATA_WIDTH-1:0] q_a;
    logic                  valid_a;

    logic                  req_b;
    logic                  we_b;
    logic [BYTES-1:0]      be_b;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [DATA_WIDTH-1:0] data_b;
    logic [DATA_WIDTH-1:0] q_b;
    logic                  valid_b;

    modport master (
        input  ready,
        output req_a, we_a, be_a, addr_a, data_a,
        input  q_a, valid_a,
        output req_b, we_b, be_b, addr_b, data_b,
        input  q_b, valid_b
    );

    modport slave (
        output ready,
        input  req_a, we_a, be_a, addr_a, data_a,
        output q_a, valid_a,
        input  req_b, we_b, be_b, addr_b, data_b,
        output q_b, valid_b
    );

endinterface

// File: rtl/sram_rsp_pipe.sv
// Response pipeline: LATENCY register stages carrying valid and read data.
//   clk, rst : clock, synchronous active-high clear (drops in-flight responses)
//   i_valid  : response launched this cycle
//   i_data   : read data for that response
//   o_valid  : response visible, one-cycle pulse
//   o_data   : response data, holds its last value while o_valid is low
module sram_rsp_pipe #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic                  r_vld [LATENCY];
    logic [DATA_WIDTH-1:0] r_dat [LATENCY];

    // Data stages only load on a valid so the output holds between responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(LATENCY); k++) begin
                r_vld[k] <= 1'b0;
                r_dat[k] <= '0;
            end
        end else begin
            r_vld[0] <= i_valid;
            if (i_valid) begin
                r_dat[0] <= i_data;
            end
            for (int k = 1; k < int'(LATENCY); k++) begin
                r_vld[k] <= r_vld[k-1];
                if (r_vld[k-1]) begin
                    r_dat[k] <= r_dat[k-1];
                end
            end
        end
    end

    assign o_valid = r_vld[LATENCY-1];
    assign o_data  = r_dat[LATENCY-1];

endmodule

// File: rtl/sram_dp_be.sv
// Dual-port byte-addressable SRAM with per-byte enables, unaligned wrapping
// access, port-A-wins write collisions, selectable read-during-write mode,
// pipelined responses and a post-reset zero-fill sweep.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of sram_dp_be_if (ready, two request/response ports)
module sram_dp_be
    import sram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned READ_LATENCY = 1,
    parameter rw_mode_e    RW_MODE      = WRITE_FIRST
) (
    input  logic         clk,
    input  logic         rst,
    sram_dp_be_if.slave  bus
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned WORDS = DEPTH / BYTES;
    localparam int unsigned CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [7:0]            r_mem [DEPTH];

    sweep_state_e          r_state;
    sweep_state_e          w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  w_sweep;
    logic                  r_ready;

    logic                  w_acc_a;
    logic                  w_acc_b;
    logic                  w_wr_a;
    logic                  w_wr_b;
    logic [ADDR_WIDTH-1:0] w_la_a [BYTES];
    logic [ADDR_WIDTH-1:0] w_la_b [BYTES];
    logic [ADDR_WIDTH-1:0] w_la_sw [BYTES];
    logic [DATA_WIDTH-1:0] w_rd_a;
    logic [DATA_WIDTH-1:0] w_rd_b;

    assign w_acc_a   = bus.req_a && r_ready;
    assign w_acc_b   = bus.req_b && r_ready;
    assign w_wr_a    = w_acc_a && bus.we_a;
    assign w_wr_b    = w_acc_b && bus.we_b;
    assign bus.ready = r_ready;

    // Sweep state register; ready is registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= (w_state_nxt == ST_RUN);
        end
    end

    // Sweep next state: clear one word per cycle, leave INIT after the last.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sweep     = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_sweep   = 1'b1;
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(WORDS - 1)) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end
            end
            ST_RUN:  w_sweep = 1'b0;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // Wrapped byte address of every lane for both ports and the sweep.
    always_comb begin
        for (int i = 0; i < int'(BYTES); i++) begin
            w_la_a[i]  = ADDR_WIDTH'(lane_addr(32'(bus.addr_a), 32'(i)));
            w_la_b[i]  = ADDR_WIDTH'(lane_addr(32'(bus.addr_b), 32'(i)));
            w_la_sw[i] = ADDR_WIDTH'(lane_addr(32'(r_cnt) * BYTES, 32'(i)));
        end
    end

    // Byte array; port A writes land last so A wins a shared byte.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_sweep) begin
                for (int i = 0; i < int'(BYTES); i++) begin
                    r_mem[w_la_sw[i]] <= 8'h00;
                end
            end
            for (int i = 0; i < int'(BYTES); i++) begin
                if (w_wr_b && bus.be_b[i]) begin
                    r_mem[w_la_b[i]] <= bus.data_b[8*i +: 8];
                end
            end
            for (int i = 0; i < int'(BYTES); i++) begin
                if (w_wr_a && bus.be_a[i]) begin
                    r_mem[w_la_a[i]] <= bus.data_a[8*i +: 8];
                end
            end
        end
    end

    // Read data; in WRITE_FIRST mode forward this cycle's write bytes,
    // B first so a colliding A byte overrides it as in the array.
    always_comb begin
        w_rd_a = '0;
        w_rd_b = '0;
        for (int i = 0; i < int'(BYTES); i++) begin
            w_rd_a[8*i +: 8] = r_mem[w_la_a[i]];
            w_rd_b[8*i +: 8] = r_mem[w_la_b[i]];
            if (RW_MODE == WRITE_FIRST) begin
                for (int j = 0; j < int'(BYTES); j++) begin
                    if (w_wr_b && bus.be_b[j]) begin
                        if (w_la_b[j] == w_la_a[i]) w_rd_a[8*i +: 8] = bus.data_b[8*j +: 8];
                        if (w_la_b[j] == w_la_b[i]) w_rd_b[8*i +: 8] = bus.data_b[8*j +: 8];
                    end
                end
                for (int j = 0; j < int'(BYTES); j++) begin
                    if (w_wr_a && bus.be_a[j]) begin
                        if (w_la_a[j] == w_la_a[i]) w_rd_a[8*i +: 8] = bus.data_a[8*j +: 8];
                        if (w_la_a[j] == w_la_b[i]) w_rd_b[8*i +: 8] = bus.data_a[8*j +: 8];
                    end
                end
            end
        end
    end

    sram_rsp_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LATENCY    (READ_LATENCY)
    ) u_pipe_a (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_acc_a),
        .i_data  (w_rd_a),
        .o_valid (bus.valid_a),
        .o_data  (bus.q_a)
    );

    sram_rsp_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LATENCY    (READ_LATENCY)
    ) u_pipe_b (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_acc_b),
        .i_data  (w_rd_b),
        .o_valid (bus.valid_b),
        .o_data  (bus.q_b)
    );

endmodule

// File: tb/tb_sram_dp_be.sv
// Directed bench: one WRITE_FIRST/latency-1 and one READ_FIRST/latency-2
// instance, 32-bit words over 256 bytes, driven with identical stimulus.
module tb_sram_dp_be;
    import sram_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_a, we_a, req_b, we_b;
    logic [3:0]  be_a, be_b;
    logic [7:0]  addr_a, addr_b;
    logic [31:0] data_a, data_b;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] qa_wf, qb_wf, qa_rf, qb_rf, qa_wf_hold;
    logic [3:0]  vld;

    always #5 clk = ~clk;

    sram_dp_be_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus_wf ();
    sram_dp_be_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus_rf ();

    assign bus_wf.req_a = req_a;   assign bus_rf.req_a = req_a;
    assign bus_wf.we_a = we_a;     assign bus_rf.we_a = we_a;
    assign bus_wf.be_a = be_a;     assign bus_rf.be_a = be_a;
    assign bus_wf.addr_a = addr_a; assign bus_rf.addr_a = addr_a;
    assign bus_wf.data_a = data_a; assign bus_rf.data_a = data_a;
    assign bus_wf.req_b = req_b;   assign bus_rf.req_b = req_b;
    assign bus_wf.we_b = we_b;     assign bus_rf.we_b = we_b;
    assign bus_wf.be_b = be_b;     assign bus_rf.be_b = be_b;
    assign bus_wf.addr_b = addr_b; assign bus_rf.addr_b = addr_b;
    assign bus_wf.data_b = data_b; assign bus_rf.data_b = data_b;
    assign vld = {bus_wf.valid_a, bus_wf.valid_b, bus_rf.valid_a, bus_rf.valid_b};

    sram_dp_be #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .READ_LATENCY(1), .RW_MODE(WRITE_FIRST)
    ) u_dut_wf (
        .clk (clk),
        .rst (rst),
        .bus (bus_wf)
    );

    sram_dp_be #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .READ_LATENCY(2), .RW_MODE(READ_FIRST)
    ) u_dut_rf (
        .clk (clk),
        .rst (rst),
        .bus (bus_rf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request cycle on both ports; captures responses of both instances.
    task automatic access(input string tag,
                          input logic ra, input logic wa, input logic [3:0] bea,
                          input logic [7:0] aa, input logic [31:0] da,
                          input logic rb, input logic wb, input logic [3:0] beb,
                          input logic [7:0] ab, input logic [31:0] db);
        req_a = ra; we_a = wa; be_a = bea; addr_a = aa; data_a = da;
        req_b = rb; we_b = wb; be_b = beb; addr_b = ab; data_b = db;
        tick();
        req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
        chk({tag, "_vld1"}, 32'(vld), 32'({ra, rb, 2'b00}));
        qa_wf = bus_wf.q_a;
        qb_wf = bus_wf.q_b;
        tick();
        chk({tag, "_vld2"}, 32'(vld), 32'({2'b00, ra, rb}));
        qa_rf = bus_rf.q_a;
        qb_rf = bus_rf.q_b;
        qa_wf_hold = bus_wf.q_a;
    endtask

    // Counts cycles until ready while holding a request that must be ignored.
    task automatic sweep(input string tag);
        int   cnt;
        logic any_vld;
        cnt = 0;
        any_vld = 1'b0;
        req_a = 1'b1; we_a = 1'b0; addr_a = 8'h10;
        while (!bus_wf.ready && cnt < 200) begin
            tick();
            cnt++;
            any_vld = any_vld | (|vld);
        end
        req_a = 1'b0;
        chk({tag, "_ready_cycles"}, 32'(cnt), 32'd64);
        chk({tag, "_ready_rf"}, 32'(bus_rf.ready), 32'd1);
        chk({tag, "_no_valid"}, 32'(any_vld), 32'd0);
    endtask

    logic [7:0]  bb_addr [3];
    logic [31:0] bb_exp  [3];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req_a = 1'b0; we_a = 1'b0; be_a = 4'h0; addr_a = 8'h00; data_a = 32'h0;
        req_b = 1'b0; we_b = 1'b0; be_b = 4'h0; addr_b = 8'h00; data_b = 32'h0;
        tick();
        chk("rst_ready", 32'({bus_wf.ready, bus_rf.ready}), 32'd0);
        chk("rst_valid", 32'(vld), 32'd0);
        chk("rst_q_wf", bus_wf.q_a | bus_wf.q_b, 32'h0);
        chk("rst_q_rf", bus_rf.q_a | bus_rf.q_b, 32'h0);
        rst = 1'b0;
        sweep("init");

        // never-written word reads zero
        access("rd40", 1, 0, 4'h0, 8'h40, 32'h0, 0, 0, 4'h0, 8'h0, 32'h0);
        chk("rd40_wf", qa_wf, 32'h0);
        chk("rd40_rf", qa_rf, 32'h0);

        // full word write: new data returned in WRITE_FIRST, old in READ_FIRST
        access("wr10", 1, 1, 4'hF, 8'h10, 32'hDDCCBBAA, 0, 0, 4'h0, 8'h0, 32'h0);
        chk("wr10_wf", qa_wf, 32'hDDCCBBAA);
        chk("wr10_rf", qa_rf, 32'h0);
        chk("wr10_hold", qa_wf_hold, 32'hDDCCBBAA);
        access("rd12", 0, 0, 4'h0, 8'h0, 32'h0, 1, 0, 4'h0, 8'h12, 32'h0);
        chk("rd12_wf", qb_wf, 32'h0000DDCC);
        chk("rd12_rf", qb_rf, 32'h0000DDCC);
        access("rd11", 1, 1, 4'h0, 8'h11, 32'hFFFFFFFF, 0, 0, 4'h0, 8'h0, 32'h0);
        chk("rd11_wf", qa_wf, 32'h00DDCCBB);
        chk("rd11_rf", qa_rf, 32'h00DDCCBB);

        // partial byte enables
        access("be20", 1, 1, 4'b0101, 8'h20, 32'h11223344, 0, 0, 4'h0, 8'h0, 32'h0);
        chk("be20_wf", qa_wf, 32'h00220044);
        access("rd20", 0, 0, 4'h0, 8'h0, 32'h0, 1, 0, 4'h0, 8'h20, 32'h0);
        chk("rd20_wf", qb_wf, 32'h00220044);
        chk("rd20_rf", qb_rf, 32'h00220044);

        // full collision: port A wins every byte
        access("col30", 1, 1, 4'hF, 8'h30, 32'hAAAAAAAA, 1, 1, 4'hF, 8'h30, 32'hBBBBBBBB);
        chk("col30_wf_b", qb_wf, 32'hAAAAAAAA);
        chk("col30_rf_b", qb_rf, 32'h0);
        access("rd30", 1, 0, 4'h0, 8'h30, 32'h0, 0, 0, 4'h0, 8'h0, 32'h0);
        chk("rd30_rf", qa_rf, 32'hAAAAAAAA);

        // partial overlap: bytes 0x52/0x53 go to A, 0x54/0x55 keep B
        access("col50", 1, 1, 4'hF, 8'h50, 32'hAAAAAAAA, 1, 1, 4'hF, 8'h52, 32'hBBBBBBBB);
        chk("col50_wf_a", qa_wf, 32'hAAAAAAAA);
        chk("col50_wf_b", qb_wf, 32'hBBBBAAAA);
        access("rd50", 1, 0, 4'h0, 8'h50, 32'h0, 1, 0, 4'h0, 8'h54, 32'h0);
        chk("rd50_rf", qa_rf, 32'hAAAAAAAA);
        chk("rd54_rf", qb_rf, 32'h0000BBBB);
        chk("rd54_wf", qb_wf, 32'h0000BBBB);

        // wrap past the top byte
        access("wrFE", 1, 1, 4'hF, 8'hFE, 32'h04030201, 0, 0, 4'h0, 8'h0, 32'h0);
        access("rdFF", 1, 0, 4'h0, 8'hFF, 32'h0, 1, 0, 4'h0, 8'h00, 32'h0);
        chk("rdFF_wf", qa_wf, 32'h00040302);
        chk("rd00_rf", qb_rf, 32'h00000403);

        // cross-port read of a byte being written
        access("x60a", 1, 1, 4'hF, 8'h60, 32'h55667788, 1, 0, 4'h0, 8'h60, 32'h0);
        chk("x60a_wf", qb_wf, 32'h55667788);
        chk("x60a_rf", qb_rf, 32'h0);
        access("x60b", 1, 1, 4'hF, 8'h60, 32'h99999999, 1, 0, 4'h0, 8'h61, 32'h0);
        chk("x60b_wf", qb_wf, 32'h00999999);
        chk("x60b_rf", qb_rf, 32'h00556677);

        // back-to-back reads on port A, one per cycle
        bb_addr[0] = 8'h10; bb_addr[1] = 8'h20; bb_addr[2] = 8'h50;
        bb_exp[0] = 32'hDDCCBBAA; bb_exp[1] = 32'h00220044; bb_exp[2] = 32'hAAAAAAAA;
        for (int k = 0; k < 4; k++) begin
            req_a = (k < 3);
            we_a = 1'b0;
            addr_a = bb_addr[(k < 3) ? k : 2];
            tick();
            chk("b2b_vld_wf", 32'(bus_wf.valid_a), 32'(k < 3));
            chk("b2b_vld_rf", 32'(bus_rf.valid_a), 32'(k > 0));
            if (k < 3) chk("b2b_q_wf", bus_wf.q_a, bb_exp[k]);
            if (k > 0) chk("b2b_q_rf", bus_rf.q_a, bb_exp[k-1]);
        end
        req_a = 1'b0;

        // reset with a latency-2 response in flight
        req_a = 1'b1; we_a = 1'b0; addr_a = 8'h10;
        tick();
        req_a = 1'b0;
        rst = 1'b1;
        tick();
        chk("mid_rst_vld", 32'(vld), 32'd0);
        chk("mid_rst_q_rf", bus_rf.q_a, 32'h0);
        chk("mid_rst_ready", 32'({bus_wf.ready, bus_rf.ready}), 32'd0);
        rst = 1'b0;
        sweep("resweep");
        access("post10", 1, 0, 4'h0, 8'h10, 32'h0, 1, 0, 4'h0, 8'h50, 32'h0);
        chk("post10_wf", qa_wf, 32'h0);
        chk("post10_rf", qa_rf, 32'h0);
        chk("post50_rf", qb_rf, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
